// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: op, direction and FSM state encodings shared by the shift datapath
package alu_shift_pkg;
    localparam logic [1:0] OP_LOG = 2'b00;
    localparam logic [1:0] OP_ARI = 2'b01;
    localparam logic [1:0] OP_ROT = 2'b10;
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result handshakes of the multi-position shifter
interface shift_sequencer_if #(parameter int WIDTH = 32, parameter int AMT_W = 5);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [AMT_W-1:0] amt;
    logic [1:0]       op;
    logic             drxn;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             busy;
    modport master (output in_valid, din, amt, op, drxn, out_ready,
                    input in_ready, out_valid, dout, busy);
    modport slave  (input in_valid, din, amt, op, drxn, out_ready,
                    output in_ready, out_valid, dout, busy);
endinterface

// File: rtl/shift_unit.sv
// shift_unit: single-position logical/arithmetic/rotate shift, one mux level
module shift_unit #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] b,
    input  logic             L,
    input  logic             A,
    input  logic             R,
    input  logic             drxn,
    output logic [WIDTH-1:0] B
);
    logic fill_r, fill_l;
    // Only the incoming bit differs between the three modes; arithmetic left fills 0.
    always_comb begin
        fill_r = R ? b[0] : (A ? b[WIDTH-1] : 1'b0);
        fill_l = R ? b[WIDTH-1] : 1'b0;
        B = !(L | A | R) ? b : drxn ? {fill_r, b[WIDTH-1:1]} : {b[WIDTH-2:0], fill_l};
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: iterates shift_unit once per clock for up to 31 positions,
// with valid/ready on both the request and the result side
module shift_sequencer
    import alu_shift_pkg::*;
#(parameter int WIDTH = 32, parameter int AMT_W = 5) (
    input logic              clk,
    input logic              rst_n,
    shift_sequencer_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       op_r;
    logic             drxn_r;
    logic             sel_l, sel_a, sel_r;
    // Reserved op 11 falls through to logical.
    always_comb begin
        sel_a = op_r == OP_ARI;
        sel_r = op_r == OP_ROT;
        sel_l = !(sel_a | sel_r);
    end
    shift_unit #(.WIDTH(WIDTH)) u_shift (
        .b(acc), .L(sel_l), .A(sel_a), .R(sel_r), .drxn(drxn_r), .B(acc_nxt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            cnt    <= '0;
            op_r   <= OP_LOG;
            drxn_r <= DIR_L;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    acc    <= bus.din;
                    cnt    <= bus.amt;
                    op_r   <= bus.op;
                    drxn_r <= bus.drxn;
                    state  <= bus.amt == '0 ? S_DONE : S_SHIFT;
                end
                S_SHIFT: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == AMT_W'(1)) state <= S_DONE;
                end
                S_DONE: if (bus.out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
    assign bus.in_ready  = state == S_IDLE;
    assign bus.out_valid = state == S_DONE;
    assign bus.busy      = state != S_IDLE;
    assign bus.dout      = acc;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed and randomized checks against an arithmetic shift model
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    shift_sequencer_if #(.WIDTH(32), .AMT_W(5)) bus();
    shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int n, input logic [1:0] op, input logic dir);
        logic [63:0] dd;
        logic [63:0] t;
        dd = {d, d};
        if (op == 2'b10) begin
            t = dir ? dd >> n : dd << n;
            return dir ? t[31:0] : t[63:32];
        end
        if (op == 2'b01 && dir) return $unsigned($signed(d) >>> n);
        return dir ? d >> n : d << n;
    endfunction
    task automatic run_op(input logic [31:0] d, input int n, input logic [1:0] op, input logic dir,
                          input int hold, input string tag);
        logic [31:0] exp;
        int lat;
        exp = ref_shift(d, n, op, dir);
        bus.din = d; bus.amt = n[4:0]; bus.op = op; bus.drxn = dir; bus.in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.din = $urandom; bus.amt = 5'($urandom); bus.op = 2'($urandom); bus.drxn = 1'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(n + 1));
        check({tag, "_dout"}, bus.dout, exp);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        repeat (hold) begin
            bus.in_valid = 1'b1;
            bus.din = $urandom;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_dout"}, bus.dout, exp);
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask
    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.din = '0; bus.amt = '0; bus.op = '0; bus.drxn = 1'b0;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_dout", bus.dout, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h8000_00F0, 4, 2'b00, 1'b1, 0, "lsr4");
        check("lsr4_model", ref_shift(32'h8000_00F0, 4, 2'b00, 1'b1), 32'h0800_000F);
        run_op(32'h8000_0000, 31, 2'b01, 1'b1, 0, "asr31");
        run_op(32'h8000_0000, 1, 2'b01, 1'b0, 0, "asl1");
        run_op(32'h8000_0001, 1, 2'b10, 1'b0, 0, "rol1");
        run_op(32'h0000_0001, 4, 2'b10, 1'b1, 0, "ror4");
        run_op(32'h8000_0001, 1, 2'b11, 1'b0, 0, "rsv1");
        run_op(32'hDEAD_BEEF, 0, 2'b10, 1'b1, 0, "zero");
        run_op(32'h1234_5678, 7, 2'b00, 1'b0, 3, "bp");
        bus.din = 32'h0000_FFFF; bus.amt = 5'd10; bus.op = 2'b00; bus.drxn = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_dout", bus.dout, 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h0000_00FF, 8, 2'b00, 1'b0, 0, "post_rst");
        for (int i = 0; i < 40; i++)
            run_op($urandom, int'($urandom_range(0, 31)), 2'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "rnd");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-position shift/rotate engine for the 32-bit ALU. It accepts an operand, a shift amount (0-31), an operation and a direction over a valid/ready handshake. It then iterates the existing single-position `shift_unit` once per clock until the requested amount is reached, and returns the result over a second valid/ready handshake. It sits between the ALU operand/decode stage and the ALU result mux.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported, because it must match `shift_unit`.
- `AMT_W`, 5: shift-amount width, equal to log2(`WIDTH`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: a request is present.
- `in_ready` output 1: the block can accept a request.
- `din` input `WIDTH`: operand.
- `amt` input `AMT_W`: number of positions to shift.
- `op` input 2: operation. 00 = logical, 01 = arithmetic, 10 = rotate, 11 = reserved (executed as logical).
- `drxn` input 1: direction. 0 = left, 1 = right.
- `out_valid` output 1: the result is available.
- `out_ready` input 1: downstream accepts the result.
- `dout` output `WIDTH`: result.
- `busy` output 1: high in SHIFT and DONE.

## Operation
- **States:** IDLE, SHIFT, DONE. The state register is reset to IDLE.
- **IDLE:** `in_ready`=1. On `in_valid`&`in_ready`, register `din`→`acc`, `amt`→`cnt`, `op`, `drxn`.
  - `amt`==0: next state is DONE.
  - `amt`≠0: next state is SHIFT.
- **SHIFT:** each clock, `acc` <= `shift_unit`(`acc`) and `cnt` <= `cnt`-1. When `cnt`==1, next state is DONE. `in_ready`=0.
- **DONE:** `out_valid`=1 and `dout`=`acc`. `acc` and `dout` stay frozen while `out_ready`=0. On `out_valid`&`out_ready`, next state is IDLE. `in_ready`=0 in DONE, so there is no accept-while-completing.
- **`shift_unit` controls:** decoded from the registered `op` into exactly one of `L`, `A`, `R`. `drxn` is driven from the registered `drxn`.
- **Per-step result semantics:**
  - Logical left/right: fill with 0.
  - Arithmetic right: fill with `acc[31]`.
  - Arithmetic left: identical to logical left (fill 0).
  - Rotate left/right: the bit shifted out re-enters at the opposite end.
- `cnt` never underflows; the FSM leaves SHIFT on the `cnt`==1 step.
- Inputs are sampled only at the accept edge. Changes to `din`, `amt`, `op` or `drxn` afterwards have no effect on the operation in flight.
- `in_valid` while not in IDLE is ignored; it is not queued.
- **Reset values:** state IDLE, `acc`=0, `cnt`=0, `dout`=0, `out_valid`=0, `busy`=0, `in_ready`=1.
- **Reset mid-operation (SHIFT or DONE):** the operation is discarded and the block returns to IDLE immediately (asynchronous). The next accept is possible on the first edge after `rst_n` deasserts.

## Timing
- **Latency:** for `amt`=N, `out_valid` rises N+1 cycles after the accept edge. N=0 gives 1 cycle; N=31 gives 32 cycles.
- **Throughput:** one operation per N+2 cycles when `out_ready` is held high.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- `dout` is registered (`acc`), so there is no combinational path from `din` to `dout`.
- The `shift_unit` combinational path is one 2:1 mux level, registered every cycle.

## Structure
- **Shared package `alu_shift_pkg`:**
  - Op encodings: `OP_LOG`=2'b00, `OP_ARI`=2'b01, `OP_ROT`=2'b10.
  - Direction constants: `DIR_L`=0, `DIR_R`=1.
  - State encodings: `S_IDLE`, `S_SHIFT`, `S_DONE`.
- **Sub-module:** one instance of the existing `shift_unit`, with `b`=`acc`, `B` feeding the `acc` next-value mux.
- No other sub-modules: FSM, counter and op decode stay in `shift_sequencer`.

## Test plan
- **Logical right:** `din`=0x8000_00F0, `amt`=4, `op`=00, `drxn`=1 → `dout`=0x0800_000F; `out_valid` rises exactly 5 cycles after accept.
- **Arithmetic right and left:**
  - `din`=0x8000_0000, `amt`=31, `op`=01, `drxn`=1 → 0xFFFF_FFFF after 32 cycles.
  - Same operand with `drxn`=0, `amt`=1 → 0x0000_0000.
- **Rotate:**
  - `din`=0x8000_0001, `amt`=1, `op`=10, `drxn`=0 → 0x0000_0003.
  - `din`=0x0000_0001, `amt`=4, `drxn`=1 → 0x1000_0000.
  - `op`=11 with `din`=0x8000_0001, `amt`=1, `drxn`=0 → 0x0000_0002 (executed as logical).
- **Zero amount:** `din`=0xDEAD_BEEF, `amt`=0 → `dout`=0xDEAD_BEEF with `out_valid` the cycle after accept; `shift_unit` output is never used.
- **Backpressure:** hold `out_ready`=0 for 3 cycles in DONE.
  - `out_valid`=1 and `dout` stay stable; `in_ready`=0; a new `in_valid` pulse is ignored.
  - After the handshake, `in_ready`=1 on the next cycle.
- **Async reset:** assert `rst_n`=0 three cycles into an `amt`=10 operation.
  - `out_valid`, `busy` and `dout` go to 0 without waiting for a clock edge.
  - After release, a new request (0x0000_00FF, `amt`=8, logical left) returns 0x0000_FF00.
